// File: rtl/timer_unit_if.sv
// -----------------------------------------------------------------------------
// timer_unit_if
// Register-access port between the processor load/store unit and the machine
// timer. Every access completes in the single cycle its strobe is high.
//   sel    : access strobe, valid for one cycle
//   we     : write enable, qualified by sel
//   addr   : byte offset into the register window (bits [1:0] ignored)
//   wdata  : write data
//   rdata  : read data (combinational, 0 when not reading)
// Modports: master (LSU side), slave (timer side).
// -----------------------------------------------------------------------------
interface timer_unit_if;
    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
// RISC-V machine timer: 64-bit mtime advanced by a programmable prescaler,
// 64-bit mtimecmp, and a registered level interrupt raised while
// mtime >= mtimecmp (gated by irq_en).
//
// Parameters:
//   PRESCALE  : clock cycles per mtime tick, 1..65535
//   CMP_RESET : reset value of mtimecmp
// Ports:
//   clk             : system clock, rising edge
//   rst             : asynchronous active-low reset
//   bus             : register access port (timer_unit_if.slave)
//   timer_interrupt : machine timer interrupt request, level, registered
//
// Register map (word offsets): 0x00 mtime_lo, 0x04 mtime_hi,
// 0x08 mtimecmp_lo, 0x0C mtimecmp_hi, 0x10 ctrl {irq_en, cnt_en},
// 0x14..0x1C read as zero, writes ignored.
//
// Optional feature macro TIMER_HI_LATCH_EN: a read of mtime_lo latches the
// upper half into a shadow register that mtime_hi reads return afterwards,
// giving software a coherent 64-bit snapshot. Without it, mtime_hi reads the
// live upper half and software uses a hi-lo-hi retry.
// -----------------------------------------------------------------------------
module timer_unit #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    timer_unit_if.slave     bus,
    output logic            timer_interrupt
);

    localparam logic [15:0] PRESC_LAST  = 16'(PRESCALE - 1);

    localparam logic [2:0]  W_MTIME_LO  = 3'd0;
    localparam logic [2:0]  W_MTIME_HI  = 3'd1;
    localparam logic [2:0]  W_CMP_LO    = 3'd2;
    localparam logic [2:0]  W_CMP_HI    = 3'd3;
    localparam logic [2:0]  W_CTRL      = 3'd4;

    logic [15:0] presc_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        cnt_en_r;
    logic        irq_en_r;
    logic        irq_r;

    logic [2:0]  word_s;
    logic        wr_s;
    logic        rd_s;
    logic        tick_s;
    logic        cmp_s;
    logic        addr_unused_s;

    assign word_s        = bus.addr[4:2];
    assign addr_unused_s = ^bus.addr[1:0];
    assign wr_s          = bus.sel & bus.we;
    assign rd_s          = bus.sel & ~bus.we;
    assign tick_s        = cnt_en_r & (presc_r == PRESC_LAST);
    assign cmp_s         = (mtime_r >= mtimecmp_r);

    // Prescaler and mtime: a software write to either mtime half wins over a
    // same-cycle tick, so the increment (and any carry into the other half)
    // is dropped and the prescaler restarts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= 16'd0;
            mtime_r <= 64'd0;
        end else if (wr_s && (word_s == W_MTIME_LO)) begin
            mtime_r[31:0] <= bus.wdata;
            presc_r       <= 16'd0;
        end else if (wr_s && (word_s == W_MTIME_HI)) begin
            mtime_r[63:32] <= bus.wdata;
            presc_r        <= 16'd0;
        end else if (tick_s) begin
            mtime_r <= mtime_r + 64'd1;
            presc_r <= 16'd0;
        end else if (cnt_en_r) begin
            presc_r <= presc_r + 16'd1;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Compare register and control bits, written by software only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp_r <= CMP_RESET;
            cnt_en_r   <= 1'b1;
            irq_en_r   <= 1'b1;
        end else if (wr_s) begin
            case (word_s)
                W_CMP_LO: mtimecmp_r[31:0]  <= bus.wdata;
                W_CMP_HI: mtimecmp_r[63:32] <= bus.wdata;
                W_CTRL: begin
                    cnt_en_r <= bus.wdata[0];
                    irq_en_r <= bus.wdata[1];
                end
                default: begin
                    mtimecmp_r <= mtimecmp_r;
                end
            endcase
        end else begin
            mtimecmp_r <= mtimecmp_r;
        end
    end

    // Interrupt request: compares the pre-edge register values, so any change
    // of mtime, mtimecmp or irq_en shows on the pin exactly one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= cmp_s & irq_en_r;
        end
    end

    assign timer_interrupt = irq_r;

`ifdef TIMER_HI_LATCH_EN
    logic [31:0] shadow_r;

    // Upper-half snapshot: captured on a read of mtime_lo, overwritten by a
    // write of mtime_hi so the shadow never returns stale software data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_r <= 32'd0;
        end else if (wr_s && (word_s == W_MTIME_HI)) begin
            shadow_r <= bus.wdata;
        end else if (rd_s && (word_s == W_MTIME_LO)) begin
            shadow_r <= mtime_r[63:32];
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

    // Read mux: combinational so the access completes in its sel cycle; the
    // value returned is the register content before this cycle's edge.
    always_comb begin
        bus.rdata = 32'd0;
        if (rd_s) begin
            case (word_s)
                W_MTIME_LO: bus.rdata = mtime_r[31:0];
`ifdef TIMER_HI_LATCH_EN
                W_MTIME_HI: bus.rdata = shadow_r;
`else
                W_MTIME_HI: bus.rdata = mtime_r[63:32];
`endif
                W_CMP_LO:   bus.rdata = mtimecmp_r[31:0];
                W_CMP_HI:   bus.rdata = mtimecmp_r[63:32];
                W_CTRL:     bus.rdata = {30'd0, irq_en_r, cnt_en_r};
                default:    bus.rdata = 32'd0;
            endcase
        end else begin
            bus.rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
// Two timer instances: PRESCALE=1 (directed table and corner sequences) and
// PRESCALE=4 (prescaler timing, tick/write priority, async reset and a
// randomized run against a behavioural model of the register map).
// -----------------------------------------------------------------------------
module tb_timer_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq1;
    logic irq4;

    int checks = 0;
    int errors = 0;

    timer_unit_if bus1 ();
    timer_unit_if bus4 ();

    timer_unit #(.PRESCALE(1)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus1.slave),
        .timer_interrupt (irq1)
    );

    timer_unit #(.PRESCALE(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus4.slave),
        .timer_interrupt (irq4)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sel;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [26];

    // ---------------- behavioural model (PRESCALE = 4 instance) -------------
    localparam int MP = 4;
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    int          m_elapsed;    // enabled cycles since the prescaler was last cleared
    logic        m_cnten;
    logic        m_irqen;
    logic        m_irq;
    logic [31:0] m_shadow;

    task automatic model_reset();
        m_time    = 64'd0;
        m_cmp     = 64'hFFFF_FFFF_FFFF_FFFF;
        m_elapsed = 0;
        m_cnten   = 1'b1;
        m_irqen   = 1'b1;
        m_irq     = 1'b0;
        m_shadow  = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic s, input logic w, input logic [4:0] a);
        if (!s || w) return 32'd0;
        case (a >> 2)
            0: return m_time[31:0];
`ifdef TIMER_HI_LATCH_EN
            1: return m_shadow;
`else
            1: return m_time[63:32];
`endif
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {30'd0, m_irqen, m_cnten};
            default: return 32'd0;
        endcase
    endfunction

    // One rising edge of the reference: interrupt from pre-edge values, time
    // advances once every MP enabled cycles unless software writes mtime.
    task automatic model_edge(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
        logic [63:0] t;
        int          wi;
        wi    = int'(a >> 2);
        m_irq = (m_time >= m_cmp) && m_irqen;
        t     = m_time;
        if (m_cnten) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == MP) begin
                m_elapsed = 0;
                t = t + 64'd1;
            end
        end
        if (s && !w && wi == 0) m_shadow = m_time[63:32];
        if (s && w) begin
            case (wi)
                0: begin t = {m_time[63:32], d}; m_elapsed = 0; end
                1: begin t = {d, m_time[31:0]}; m_elapsed = 0; m_shadow = d; end
                2: m_cmp = {m_cmp[63:32], d};
                3: m_cmp = {d, m_cmp[31:0]};
                4: begin m_cnten = d[0]; m_irqen = d[1]; end
                default: ;
            endcase
        end
        m_time = t;
    endtask

    // ---------------- helpers ------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
        bus1.sel = 1'b0; bus1.we = 1'b0; bus1.addr = 5'd0; bus1.wdata = 32'd0;
        bus4.sel = 1'b0; bus4.we = 1'b0; bus4.addr = 5'd0; bus4.wdata = 32'd0;
        if (which == 1) begin
            bus1.sel = s; bus1.we = w; bus1.addr = a; bus1.wdata = d;
        end else begin
            bus4.sel = s; bus4.we = w; bus4.addr = a; bus4.wdata = d;
        end
    endtask

    // One bus cycle: drive after the falling edge, sample 1 time unit later.
    task automatic cyc(input int which, input logic s, input logic w, input logic [4:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic irq);
        @(negedge clk);
        drive(which, s, w, a, d);
        #1;
        if (which == 1) begin rd = bus1.rdata; irq = irq1; end
        else begin rd = bus4.rdata; irq = irq4; end
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        logic [31:0] rd;
        logic        irq;
        logic [31:0] exp_hi;
        logic        s, w;
        logic [4:0]  a;
        logic [31:0] d;

        tbl[0]  = '{1'b1, 1'b1, 5'h10, 32'h0000_0002, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_000C, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 5'h0C, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 5'h08, 32'h0000_000C, 32'h0000_0000, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 5'h08, 32'h0000_0000, 32'h0000_000C, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 5'h08, 32'hFFFF_0000, 32'h0000_0000, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 5'h08, 32'h0000_0000, 32'hFFFF_0000, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 5'h08, 32'h0000_0005, 32'h0000_0000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 5'h10, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 5'h10, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_000C, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 5'h10, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 5'h10, 32'h0000_0000, 32'h0000_0002, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 5'h14, 32'h0000_007B, 32'h0000_0000, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 5'h14, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[21] = '{1'b1, 1'b0, 5'h0B, 32'h0000_0000, 32'h0000_0005, 1'b1};
        tbl[22] = '{1'b1, 1'b0, 5'h0C, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[23] = '{1'b1, 1'b1, 5'h00, 32'h0000_0003, 32'h0000_0000, 1'b1};
        tbl[24] = '{1'b0, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[25] = '{1'b1, 1'b0, 5'h00, 32'h0000_0000, 32'h0000_0003, 1'b0};

        drive(1, 1'b0, 1'b0, 5'd0, 32'd0);

        // Reset state, observed while reset is held.
        cyc(1, 1'b1, 1'b0, 5'h08, 32'd0, rd, irq);
        check("rst_cmp_lo", rd, 32'hFFFF_FFFF);
        check("rst_irq", irq, 1'b0);
        cyc(1, 1'b1, 1'b0, 5'h0C, 32'd0, rd, irq);
        check("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        cyc(1, 1'b1, 1'b0, 5'h10, 32'd0, rd, irq);
        check("rst_ctrl", rd, 32'h3);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("rst_mtime_lo", rd, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 5'd0, 32'd0);

        // PRESCALE=1: tenth cycle after release sees mtime = 10.
        for (int i = 1; i < 10; i++) cyc(1, 1'b0, 1'b0, 5'd0, 32'd0, rd, irq);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("count_10", rd, 32'd10);
        check("read_rdata_idle_irq", irq, 1'b0);

        // Directed table on the PRESCALE=1 instance.
        for (int i = 0; i < 26; i++) begin
            cyc(1, tbl[i].sel, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, irq);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_irq", i), irq, tbl[i].exp_irq);
        end

        // Carry from lo into hi; the write edge itself does not increment.
        cyc(1, 1'b1, 1'b1, 5'h10, 32'h3, rd, irq);
        cyc(1, 1'b1, 1'b1, 5'h04, 32'h0, rd, irq);
        cyc(1, 1'b1, 1'b1, 5'h00, 32'hFFFF_FFFF, rd, irq);
        cyc(1, 1'b1, 1'b0, 5'h04, 32'd0, rd, irq);
        check("carry_hi_before", rd, 32'h0);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("carry_lo_after", rd, 32'h0);
        cyc(1, 1'b1, 1'b0, 5'h04, 32'd0, rd, irq);
        check("carry_hi_after", rd, 32'h1);

        // Full 64-bit wrap to zero.
        cyc(1, 1'b1, 1'b1, 5'h04, 32'hFFFF_FFFF, rd, irq);
        cyc(1, 1'b1, 1'b1, 5'h00, 32'hFFFF_FFFF, rd, irq);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("wrap_lo_before", rd, 32'hFFFF_FFFF);
        cyc(1, 1'b1, 1'b0, 5'h04, 32'd0, rd, irq);
`ifdef TIMER_HI_LATCH_EN
        exp_hi = 32'hFFFF_FFFF;
`else
        exp_hi = 32'h0;
`endif
        check("wrap_hi_after", rd, exp_hi);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("wrap_lo_after", rd, 32'h1);

        // cnt_en=0 freezes mtime for 50 cycles; writes still land.
        cyc(1, 1'b1, 1'b1, 5'h10, 32'h0, rd, irq);
        cyc(1, 1'b1, 1'b1, 5'h00, 32'h55, rd, irq);
        for (int i = 0; i < 50; i++) cyc(1, 1'b0, 1'b0, 5'd0, 32'd0, rd, irq);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("freeze_50", rd, 32'h55);

        // Snapshot of the upper half across a carry.
        cyc(1, 1'b1, 1'b1, 5'h10, 32'h3, rd, irq);
        cyc(1, 1'b1, 1'b1, 5'h04, 32'h0, rd, irq);
        cyc(1, 1'b1, 1'b1, 5'h00, 32'hFFFF_FFFE, rd, irq);
        cyc(1, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
        check("snap_lo", rd, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) cyc(1, 1'b0, 1'b0, 5'd0, 32'd0, rd, irq);
        cyc(1, 1'b1, 1'b0, 5'h04, 32'd0, rd, irq);
`ifdef TIMER_HI_LATCH_EN
        exp_hi = 32'h0;
`else
        exp_hi = 32'h1;
`endif
        check("snap_hi", rd, exp_hi);

        // PRESCALE=4: mtime write at edge E0, compare = 5, interrupt at E21.
        cyc(4, 1'b1, 1'b1, 5'h04, 32'h0, rd, irq);
        cyc(4, 1'b1, 1'b1, 5'h00, 32'h0, rd, irq);
        for (int k = 1; k <= 29; k++) begin
            case (k)
                1:       cyc(4, 1'b1, 1'b1, 5'h0C, 32'h0, rd, irq);
                2:       cyc(4, 1'b1, 1'b1, 5'h08, 32'h5, rd, irq);
                20, 21, 25, 28, 29:
                         cyc(4, 1'b1, 1'b0, 5'h00, 32'd0, rd, irq);
                24:      cyc(4, 1'b1, 1'b1, 5'h00, 32'h100, rd, irq);
                default: cyc(4, 1'b0, 1'b0, 5'd0, 32'd0, rd, irq);
            endcase
            if (k <= 22) check($sformatf("p4_irq_k%0d", k), irq, (k >= 22) ? 1'b1 : 1'b0);
            if (k == 20) check("p4_mtime_k20", rd, 32'd4);
            if (k == 21) check("p4_mtime_k21", rd, 32'd5);
            if (k == 25) check("p4_write_beats_tick", rd, 32'h100);
            if (k == 28) check("p4_presc_cleared", rd, 32'h100);
            if (k == 29) check("p4_next_tick", rd, 32'h101);
        end

        // Asynchronous reset mid-cycle with the interrupt asserted.
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 5'h08, 32'd0);
        #1;
        check("pre_async_irq", irq4, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_irq", irq4, 1'b0);
        check("async_rst_cmp", bus4.rdata, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        drive(4, 1'b0, 1'b0, 5'd0, 32'd0);
        model_reset();
        model_edge(1'b0, 1'b0, 5'd0, 32'd0);

        // Randomized traffic on the PRESCALE=4 instance against the model.
        for (int i = 0; i < 600; i++) begin
            int op;
            op = $urandom_range(0, 9);
            s = 1'b1; w = 1'b1; d = 32'd0;
            a = 5'($urandom_range(0, 31));
            case (op)
                0, 1, 2: begin s = 1'b0; w = 1'b0; a = 5'd0; end
                3, 4, 5: w = 1'b0;
                6: begin a = 5'h00; d = 32'($urandom_range(0, 40)); end
                7: begin
                    if ($urandom_range(0, 1) == 0) begin
                        a = 5'h08; d = 32'($urandom_range(0, 60));
                    end else begin
                        a = 5'h0C;
                        case ($urandom_range(0, 3))
                            0: d = 32'hFFFF_FFFF;
                            1: d = 32'h1;
                            default: d = 32'h0;
                        endcase
                    end
                end
                8: begin
                    a = 5'h10;
                    d = {$urandom_range(0, 32'h3FFF_FFFF)} << 2;
                    d[0] = ($urandom_range(0, 3) != 0);
                    d[1] = ($urandom_range(0, 2) != 0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        a = 5'h04; d = ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0;
                    end else begin
                        a = 5'(5'h14 + 5'($urandom_range(0, 11))); d = $urandom;
                    end
                end
            endcase
            cyc(4, s, w, a, d, rd, irq);
            check($sformatf("rnd%0d_rdata", i), rd, model_read(s, w, a));
            check($sformatf("rnd%0d_irq", i), irq, m_irq);
            model_edge(s, w, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_unit.md
# timer_unit

Memory-mapped RISC-V machine timer that sits directly upstream of the processor and drives its `timer_interrupt` input. Holds a 64-bit `mtime` counter advanced by a programmable-rate prescaler, and a 64-bit `mtimecmp` compare register. The processor's load/store path accesses both through a 32-bit single-cycle register port. The block raises a registered, level-sensitive interrupt while `mtime >= mtimecmp`.

## Interface
- `PRESCALE`, default 1: clock cycles per `mtime` tick; legal range 1..65535.
- `CMP_RESET`, default 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `sel`  in  1  register access strobe from the LSU, valid for one cycle.
- `we`  in  1  write enable, qualified by `sel`.
- `addr`  in  5  byte offset; bits [1:0] are ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data.
- `timer_interrupt`  out  1  machine timer interrupt request, level.

## Operation
- Register map (word offsets):
  - 0x00 `mtime_lo`
  - 0x04 `mtime_hi`
  - 0x08 `mtimecmp_lo`
  - 0x0C `mtimecmp_hi`
  - 0x10 `ctrl`: bit0 `cnt_en`, bit1 `irq_en`; other bits read 0 and ignore writes.
  - Offsets 0x14–0x1C read 0; writes to them are ignored.
- Reset values:
  - `mtime`=0, `mtimecmp`=`CMP_RESET`, prescaler=0.
  - `ctrl`=2'b11.
  - `timer_interrupt`=0, `rdata`=0.
- Prescaler:
  - 16-bit counter that increments each cycle while `cnt_en`=1.
  - On reaching `PRESCALE-1` it returns to 0 and `mtime` increments by 1.
  - With `PRESCALE`=1, `mtime` increments every cycle.
- `mtime` wraps from all-ones to 0 with no flag.
- Write to `mtime_lo` or `mtime_hi`:
  - Replaces that half with `wdata` and clears the prescaler.
  - Takes priority over a same-cycle increment; the increment is dropped, including any carry into the other half.
- `cnt_en`=0 freezes the prescaler and `mtime`; register writes still take effect.
- Compare: `cmp = (mtime >= mtimecmp)`, unsigned 64-bit, evaluated on current register values.
- `timer_interrupt <= cmp & irq_en` every cycle.
- Interrupt clears only by:
  - raising `mtimecmp`,
  - lowering `mtime`, or
  - clearing `irq_en`.
- Software protocol for reprogramming `mtimecmp` without spurious interrupts: write `mtimecmp_hi`=all-ones, then `mtimecmp_lo`, then `mtimecmp_hi`. The hardware does no interlock.
- Reads:
  - `rdata` is combinational from `addr` while `sel`=1 and `we`=0; otherwise 0.
  - A read returns the pre-edge register value.

## Timing
- Register write visible to a read on the next cycle.
- Interrupt latency is exactly one cycle.
  - Edge N: `mtime` reaches `mtimecmp`.
  - Edge N+1: `timer_interrupt` asserts.
  - The same one-cycle latency applies to clearing.
- A write of `mtimecmp` at edge N changes `timer_interrupt` at edge N+1.
- `rst` assertion forces all state to its reset values immediately, including mid-access or mid-prescale.
- Deassertion is synchronized externally. The first increment with `PRESCALE`=1 occurs on the first rising edge after deassertion.
- No back-pressure: every access completes in its `sel` cycle.

## Configuration
- `TIMER_HI_LATCH_EN` defined:
  - A read of `mtime_lo` captures `mtime[63:32]` into a 32-bit shadow register on that edge.
  - Subsequent reads of `mtime_hi` return the shadow, giving a coherent 64-bit snapshot.
  - Shadow reset value is 0.
  - A write to `mtime_hi` also updates the shadow.
- Undefined:
  - No shadow; `mtime_hi` reads the live upper half.
  - Software must use the hi-lo-hi retry sequence.

## Test plan
- Reset, `PRESCALE`=1 → `timer_interrupt`=0; read 0x08/0x0C returns 0xFFFFFFFF; read 0x00 after 10 cycles returns 10 (±1 for access cycle).
- `PRESCALE`=4, write `mtimecmp_hi`=0, `mtimecmp_lo`=5, `mtime`=0 → `mtime` advances every 4 cycles; `timer_interrupt` rises exactly one cycle after `mtime` becomes 5 (20 cycles after the `mtime` write).
- Interrupt asserted, write `mtimecmp_lo`=0xFFFF0000 → `timer_interrupt` drops the next cycle; write `ctrl`=1 (irq_en=0) with `mtime >= mtimecmp` → stays 0.
- Write `mtime`=0x00000000_FFFFFFFF, `PRESCALE`=1 → next cycle `mtime_hi`=1, `mtime_lo`=0; `mtime`=all-ones wraps to 0.
- Write `mtime_lo`=0x100 in the cycle a tick is due → reads back 0x100, not 0x101; `ctrl`=0 freezes `mtime` over 50 cycles.
- With `TIMER_HI_LATCH_EN`, `mtime`=0x00000000_FFFFFFFE, read lo, wait 5 cycles, read hi → hi=0 (shadow); without the macro → hi=1.
